// File: rtl/axis_slave.sv
// Receive-side AXI-Stream endpoint: buffers upstream beats in a FIFO and presents
// them to the backend first-word-fall-through, with frame-done and stall-timeout flags.
module axis_slave #(
    parameter int FIFO_DEPTH     = 8,
    parameter int BK_RDY_TIMEOUT = 5
) (
    input  logic        axi_aclk,
    input  logic        axi_aresetn,
    input  logic        axis_tvalid,
    input  logic [31:0] axis_tdata,
    input  logic [3:0]  axis_tstrb,
    input  logic [3:0]  axis_tkeep,
    input  logic [1:0]  axis_tuser,
    input  logic        axis_tlast,
    output logic        axis_tready,
    output logic        bk_valid,
    output logic [31:0] bk_data,
    output logic [3:0]  bk_tstrb,
    output logic [3:0]  bk_tkeep,
    output logic [1:0]  bk_user,
    output logic        bk_last,
    input  logic        bk_ready,
    output logic        bk_nordy,
    output logic        bk_done
);

    localparam int         AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [7:0] DEPTH    = 8'(FIFO_DEPTH);
    localparam logic [7:0] LAST_IDX = 8'(FIFO_DEPTH - 1);
    localparam logic [7:0] TIMEOUT  = 8'(BK_RDY_TIMEOUT);

    logic [42:0] fifo [FIFO_DEPTH];
    logic [7:0]  wr_ptr;
    logic [7:0]  rd_ptr;
    logic [7:0]  count;
    logic [7:0]  stall_cnt;
    logic        init_done;
    logic        push;
    logic        pop;
    logic [42:0] head;

    function automatic logic [7:0] ptr_inc(input logic [7:0] p);
        return (p == LAST_IDX) ? 8'd0 : p + 8'd1;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Ready depends only on registered state; no bypass when full.
    assign axis_tready = init_done && (count != DEPTH);
    assign bk_valid    = (count != 8'd0);
    assign push        = axis_tvalid && axis_tready;
    assign pop         = bk_valid && bk_ready;
    assign head        = fifo[rd_ptr[AW-1:0]];
    assign {bk_data, bk_tstrb, bk_tkeep, bk_user, bk_last} = bk_valid ? head : 43'd0;
    assign bk_nordy    = (stall_cnt >= TIMEOUT);

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            init_done <= 1'b0;
            wr_ptr    <= 8'd0;
            rd_ptr    <= 8'd0;
            count     <= 8'd0;
            stall_cnt <= 8'd0;
            bk_done   <= 1'b0;
        end else begin
            init_done <= 1'b1;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 8'd1;
                2'b01:   count <= count - 8'd1;
                default: count <= count;
            endcase
            if (pop || !bk_valid) stall_cnt <= 8'd0;
            else                  stall_cnt <= sat_inc(stall_cnt);
            bk_done <= pop && head[0];
        end
    end

    // Storage carries no reset; an empty count masks stale entries.
    always_ff @(posedge axi_aclk) begin
        if (push)
            fifo[wr_ptr[AW-1:0]] <= {axis_tdata, axis_tstrb, axis_tkeep, axis_tuser, axis_tlast};
    end

endmodule

// File: tb/tb_axis_slave.sv
// Randomized bench for axis_slave against a queue-based reference of the endpoint.
module tb_axis_slave;

    localparam int FIFO_DEPTH     = 8;
    localparam int BK_RDY_TIMEOUT = 5;

    logic        axi_aclk = 1'b0;
    logic        axi_aresetn;
    logic        axis_tvalid;
    logic [31:0] axis_tdata;
    logic [3:0]  axis_tstrb;
    logic [3:0]  axis_tkeep;
    logic [1:0]  axis_tuser;
    logic        axis_tlast;
    logic        axis_tready;
    logic        bk_valid;
    logic [31:0] bk_data;
    logic [3:0]  bk_tstrb;
    logic [3:0]  bk_tkeep;
    logic [1:0]  bk_user;
    logic        bk_last;
    logic        bk_ready;
    logic        bk_nordy;
    logic        bk_done;

    axis_slave #(.FIFO_DEPTH(FIFO_DEPTH), .BK_RDY_TIMEOUT(BK_RDY_TIMEOUT)) dut (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .axis_tvalid (axis_tvalid),
        .axis_tdata  (axis_tdata),
        .axis_tstrb  (axis_tstrb),
        .axis_tkeep  (axis_tkeep),
        .axis_tuser  (axis_tuser),
        .axis_tlast  (axis_tlast),
        .axis_tready (axis_tready),
        .bk_valid    (bk_valid),
        .bk_data     (bk_data),
        .bk_tstrb    (bk_tstrb),
        .bk_tkeep    (bk_tkeep),
        .bk_user     (bk_user),
        .bk_last     (bk_last),
        .bk_ready    (bk_ready),
        .bk_nordy    (bk_nordy),
        .bk_done     (bk_done)
    );

    always #5 axi_aclk = ~axi_aclk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: a queue of packed beats plus the observable flags.
    logic [42:0] q [$];
    bit          m_init;
    int          m_stall;
    bit          m_done;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_init  = 1'b0;
        m_stall = 0;
        m_done  = 1'b0;
    endtask

    task automatic compare_outputs();
        logic [42:0] exp_head;
        exp_head = (q.size() != 0) ? q[0] : 43'd0;
        check("tready", 64'(axis_tready), 64'(m_init && (q.size() != FIFO_DEPTH)));
        check("bk_valid", 64'(bk_valid), 64'(q.size() != 0));
        check("bk_beat", 64'({bk_data, bk_tstrb, bk_tkeep, bk_user, bk_last}), 64'(exp_head));
        check("bk_nordy", 64'(bk_nordy), 64'(m_stall >= BK_RDY_TIMEOUT));
        check("bk_done", 64'(bk_done), 64'(m_done));
    endtask

    // One clock: check before the edge, advance the reference across it.
    task automatic cycle();
        bit          tr, v, do_push, do_pop;
        logic [42:0] popped;
        @(negedge axi_aclk);
        compare_outputs();
        if (!axi_aresetn) begin
            model_reset();
        end else begin
            tr      = m_init && (q.size() != FIFO_DEPTH);
            v       = (q.size() != 0);
            do_push = axis_tvalid && tr;
            do_pop  = v && bk_ready;
            popped  = v ? q[0] : 43'd0;
            m_done  = do_pop && popped[0];
            if (do_pop || !v)    m_stall = 0;
            else if (m_stall < 255) m_stall++;
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back({axis_tdata, axis_tstrb, axis_tkeep, axis_tuser, axis_tlast});
            m_init = 1'b1;
        end
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic set_beat(input logic [31:0] d, input logic [3:0] s, input logic [3:0] k,
                            input logic [1:0] u, input logic l, input logic v);
        axis_tdata  = d;
        axis_tstrb  = s;
        axis_tkeep  = k;
        axis_tuser  = u;
        axis_tlast  = l;
        axis_tvalid = v;
    endtask

    task automatic rand_beat(input logic v, input logic l);
        set_beat($urandom, 4'($urandom), 4'($urandom), 2'($urandom), l, v);
    endtask

    task automatic apply_reset();
        axi_aresetn = 1'b0;
        #1;
        model_reset();
        compare_outputs();
        cycle();
        cycle();
        axi_aresetn = 1'b1;
    endtask

    initial begin
        axi_aresetn = 1'b0;
        bk_ready    = 1'b0;
        set_beat(32'd0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0);
        model_reset();
        #1;
        apply_reset();

        // Idle after reset: ready must come up on the second cycle.
        repeat (3) cycle();

        // Single-beat frame with immediate consumption.
        bk_ready = 1'b1;
        set_beat(32'hA5A5_0001, 4'hF, 4'hF, 2'd2, 1'b1, 1'b1);
        cycle();
        axis_tvalid = 1'b0;
        repeat (3) cycle();

        // Eight-beat frame into a stalled backend fills the FIFO.
        bk_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_beat(32'(i), 4'hF, 4'hF, 2'd0, (i == 7), 1'b1);
            cycle();
        end
        axis_tvalid = 1'b0;
        repeat (8) cycle();
        bk_ready = 1'b1;
        repeat (10) cycle();

        // Stall timeout on a single pending beat, then release.
        bk_ready = 1'b0;
        rand_beat(1'b1, 1'b1);
        cycle();
        axis_tvalid = 1'b0;
        repeat (8) cycle();
        bk_ready = 1'b1;
        repeat (3) cycle();

        // Hold occupancy at four with simultaneous push and pop.
        bk_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_beat(1'b1, 1'b0);
            cycle();
        end
        bk_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_beat(1'b1, ($urandom_range(0, 4) == 0));
            cycle();
        end
        axis_tvalid = 1'b0;
        repeat (6) cycle();

        // Random traffic, first backend-light then backend-heavy.
        for (int i = 0; i < 300; i++) begin
            rand_beat(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
            bk_ready = (i < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cycle();
        end
        axis_tvalid = 1'b0;
        bk_ready    = 1'b1;
        repeat (10) cycle();

        // Reset in the middle of a six-beat frame, then a clean two-beat frame.
        bk_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_beat(1'b1, 1'b0);
            cycle();
        end
        axis_tvalid = 1'b0;
        apply_reset();
        cycle();
        bk_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rand_beat(1'b1, (i == 1));
            cycle();
        end
        axis_tvalid = 1'b0;
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
